// File: rtl/nibble_parity_checker.sv
// Checks nibble parity against the generator's enable mask and queues checked words in a FIFO.
// Optional macro PARITY_ERR_DROP_EN: erroneous words are counted but not enqueued; QERR tied low.
module nibble_parity_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       DP,
  input  logic [3:0]       EN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic [3:0]       Q,
  output logic             QERR,
  output logic             QVALID,
  input  logic             QREADY,
  output logic [CNT_W-1:0] ERRCNT,
  output logic             ERR_STICKY,
  input  logic             CLR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic             sticky_q, sticky_d;

  logic par_err;
  logic accept;
  logic push;
  logic pop;

  assign par_err = DP[4] ^ (^(DP[3:0] & EN));
  assign DREADY  = (occ_q != FULL) & ~RST;
  assign QVALID  = (occ_q != '0);
  assign accept  = DVALID & DREADY;
  assign pop     = QVALID & QREADY;

`ifdef PARITY_ERR_DROP_EN
  logic [3:0] mem_q [DEPTH];

  assign push = accept & ~par_err;
  assign QERR = 1'b0;
  assign Q    = QVALID ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= DP[3:0];
  end
`else
  logic [4:0] mem_q [DEPTH];

  assign push = accept;
  assign QERR = QVALID & mem_q[rd_ptr_q][4];
  assign Q    = QVALID ? mem_q[rd_ptr_q][3:0] : '0;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {par_err, DP[3:0]};
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  // CLR takes priority over an error accepted in the same cycle.
  always_comb begin
    errcnt_d = errcnt_q;
    sticky_d = sticky_q;
    if (CLR) begin
      errcnt_d = '0;
      sticky_d = 1'b0;
    end else if (accept && par_err) begin
      sticky_d = 1'b1;
      if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      errcnt_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      errcnt_q <= errcnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign ERRCNT     = errcnt_q;
  assign ERR_STICKY = sticky_q;

endmodule

// File: tb/tb_nibble_parity_checker.sv
// Self-checking bench for nibble_parity_checker: directed steps then randomized traffic
// compared against a queue-based reference model (honours PARITY_ERR_DROP_EN).
module tb_nibble_parity_checker;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [4:0]       DP;
  logic [3:0]       EN;
  logic             DVALID;
  logic             DREADY;
  logic [3:0]       Q;
  logic             QERR;
  logic             QVALID;
  logic             QREADY;
  logic [CNT_W-1:0] ERRCNT;
  logic             ERR_STICKY;
  logic             CLR;

  nibble_parity_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .DP(DP), .EN(EN), .DVALID(DVALID), .DREADY(DREADY),
    .Q(Q), .QERR(QERR), .QVALID(QVALID), .QREADY(QREADY),
    .ERRCNT(ERRCNT), .ERR_STICKY(ERR_STICKY), .CLR(CLR)
  );

  always #5 CLK = ~CLK;

  int passes = 0;
  int checks = 0;

  // Reference model: FIFO as a queue of {error, nibble}
  logic [4:0]  mq[$];
  int unsigned merr = 0;
  bit          msticky = 1'b0;
  bit          last_acc = 1'b0;

`ifdef PARITY_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check outputs mid-cycle, then advance the model over the coming rising edge.
  task automatic cycle();
    bit         exp_rdy, exp_qv, acc, pop, e;
    logic [4:0] head;
    @(negedge CLK);
    exp_rdy = !RST && (mq.size() < DEPTH);
    exp_qv  = (mq.size() != 0);
    head    = exp_qv ? mq[0] : 5'd0;
    chk("dready", 8'(DREADY), 8'(exp_rdy));
    chk("qvalid", 8'(QVALID), 8'(exp_qv));
    chk("q", 8'(Q), 8'(head[3:0]));
    chk("qerr", 8'(QERR), 8'(head[4]));
    chk("errcnt", 8'(ERRCNT), 8'(merr));
    chk("sticky", 8'(ERR_STICKY), 8'(msticky));
    acc = DVALID && exp_rdy;
    pop = exp_qv && QREADY;
    e   = DP[4] ^ (^(DP[3:0] & EN));
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      merr    = 0;
      msticky = 1'b0;
    end else begin
      if (CLR) begin
        merr    = 0;
        msticky = 1'b0;
      end else if (acc && e) begin
        msticky = 1'b1;
        if (merr < CMAX) merr = merr + 1;
      end
      if (pop) void'(mq.pop_front());
      if (acc && !(DROP && e)) mq.push_back({e, DP[3:0]});
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [4:0] dp, input logic [3:0] en);
    bit done = 1'b0;
    DVALID = 1'b1;
    DP     = dp;
    EN     = en;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = last_acc;
    end
    checks++;
    assert (done) passes++;
    else $error("FAIL send_timeout: observed %0d expected %0d", done, 1);
    DVALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; DP = '0; EN = '0; DVALID = 1'b0; QREADY = 1'b0; CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    cycle();
    RST = 1'b0;
    cycle();
    chk("rst_dready", 8'(DREADY), 8'd1);
    chk("rst_qvalid", 8'(QVALID), 8'd0);
    chk("rst_errcnt", 8'(ERRCNT), 8'd0);

    // Good words
    QREADY = 1'b1;
    send(5'b1_0111, 4'b1111);
    chk("good1_q", 8'(Q), 8'h7);
    chk("good1_qerr", 8'(QERR), 8'd0);
    chk("good1_errcnt", 8'(ERRCNT), 8'd0);
    send(5'b0_0101, 4'b0101);
    chk("good2_qerr", 8'(QERR), 8'd0);
    cycle();

    // Bad word
    send(5'b0_0001, 4'b0001);
    chk("bad_qvalid", 8'(QVALID), DROP ? 8'd0 : 8'd1);
    chk("bad_qerr", 8'(QERR), DROP ? 8'd0 : 8'd1);
    chk("bad_errcnt", 8'(ERRCNT), 8'd1);
    chk("bad_sticky", 8'(ERR_STICKY), 8'd1);
    repeat (2) cycle();

    // Fill and drain
    QREADY = 1'b0;
    for (int i = 1; i <= 4; i++) send(5'(i), 4'b0000);
    chk("full_dready", 8'(DREADY), 8'd0);
    DVALID = 1'b1; DP = 5'd5; EN = 4'b0000;
    repeat (3) cycle();
    chk("full_held", 8'(DREADY), 8'd0);
    chk("full_head", 8'(Q), 8'd1);
    QREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_acc) DVALID = 1'b0;
    end
    DVALID = 1'b0;

    // Saturation and clear
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    for (int i = 0; i < 5; i++) send(5'b0_0001, 4'b0001);
    chk("sat_errcnt", 8'(ERRCNT), 8'(CMAX));
    chk("sat_sticky", 8'(ERR_STICKY), 8'd1);
    CLR = 1'b1;
    send(5'b0_0001, 4'b0001);
    CLR = 1'b0;
    chk("clr_errcnt", 8'(ERRCNT), 8'd0);
    chk("clr_sticky", 8'(ERR_STICKY), 8'd0);
    repeat (3) cycle();

    // Reset mid-stream
    QREADY = 1'b0;
    for (int i = 0; i < 3; i++) send(5'(8 + i), 4'b0000);
    RST = 1'b1;
    cycle();
    chk("rstmid_qvalid", 8'(QVALID), 8'd0);
    RST = 1'b0;
    send(5'b0_1010, 4'b0000);
    chk("rstmid_head", 8'(Q), 8'hA);
    chk("rstmid_qvalid2", 8'(QVALID), 8'd1);

    // Randomized traffic, upstream holds a word until it is accepted
    for (int n = 0; n < 500; n++) begin
      if (!DVALID || last_acc) begin
        DVALID = ($urandom_range(0, 3) != 0);
        DP     = 5'($urandom);
        EN     = 4'($urandom);
      end
      QREADY = ($urandom_range(0, 2) != 0);
      CLR    = ($urandom_range(0, 15) == 0);
      RST    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    RST = 1'b0; CLR = 1'b0; DVALID = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
